// File: rtl/clken_nco_gen.sv
// rtl/clken_nco_gen.sv - multi-channel NCO clock-enable generator with PLL lock sequencing
// Optional feature macro: CLKEN_DYN_INC_EN (runtime increment writes applied at wrap)
module clken_nco_gen #(
    parameter int                      NUM_CH      = 2,
    parameter int                      ACC_W       = 24,
    parameter logic [NUM_CH*ACC_W-1:0] INC_VEC     = '0,
    parameter int                      LOCK_CYCLES = 1024
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce,
    output logic              ready,
    output logic [7:0]        lost_cnt
`ifdef CLKEN_DYN_INC_EN
    ,
    input  logic              inc_wr,
    input  logic [1:0]        inc_sel,
    input  logic [ACC_W-1:0]  inc_data
`endif
);

    // Settle counter only needs to reach LOCK_CYCLES-1.
    localparam int CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_SETTLE    = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    logic             lk_meta;
    logic             lk;
    logic [1:0]       state;
    logic [CNT_W-1:0] settle_cnt;

    logic [ACC_W-1:0] acc [NUM_CH];
    logic [ACC_W-1:0] inc [NUM_CH];
    logic [ACC_W:0]   sum [NUM_CH];
    logic [NUM_CH-1:0] wrap;

    logic stay_run;
    logic do_add;

    // Accumulators only advance while RUN persists through this edge and no realign is requested.
    // A lock loss in RUN takes precedence over sync, so sync is only honoured while lk holds.
    always_comb begin
        stay_run = (state == ST_RUN) && lk;
        do_add   = stay_run && !sync;
    end

    // Per-channel sum with carry; the carry bit is the wrap indicator.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]  = {1'b0, acc[i]} + {1'b0, inc[i]};
            wrap[i] = do_add && sum[i][ACC_W];
        end
    end

    // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
        end
    end

    // Lock sequencer: wait for lock, require LOCK_CYCLES stable cycles, then run; count losses in RUN.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= ST_WAIT_LOCK;
            settle_cnt <= '0;
            ready      <= 1'b0;
            lost_cnt   <= 8'd0;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                    if (lk) begin
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!lk) begin
                        state      <= ST_WAIT_LOCK;
                        settle_cnt <= '0;
                    end else if (settle_cnt == CNT_LAST) begin
                        state      <= ST_RUN;
                        settle_cnt <= '0;
                        ready      <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    settle_cnt <= '0;
                    if (!lk) begin
                        state <= ST_WAIT_LOCK;
                        ready <= 1'b0;
                        if (lost_cnt != 8'hFF) begin
                            lost_cnt <= lost_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state      <= ST_WAIT_LOCK;
                    settle_cnt <= '0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    // Phase accumulators: add in RUN, register the carry as ce; anything else clears phase and enables.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                ce[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (do_add) begin
                    acc[i] <= sum[i][ACC_W-1:0];
                    ce[i]  <= sum[i][ACC_W];
                end else begin
                    acc[i] <= '0;
                    ce[i]  <= 1'b0;
                end
            end
        end
    end

`ifdef CLKEN_DYN_INC_EN
    logic [ACC_W-1:0]  staged [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] wr_hit;

    // A staged value lands immediately outside RUN, or only on its channel's wrap edge in RUN
    // so the period in flight is never truncated. Out-of-range selects hit no channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = inc_wr && (inc_sel == 2'(i));
            apply[i]  = pending[i] && ((state != ST_RUN) || wrap[i]);
        end
    end

    // Increment staging and apply; a write coinciding with an apply stays pending as the next value.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                inc[i]    <= INC_VEC[i*ACC_W +: ACC_W];
                staged[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply[i]) begin
                    inc[i] <= staged[i];
                end
                if (wr_hit[i]) begin
                    staged[i]  <= inc_data;
                    pending[i] <= 1'b1;
                end else if (apply[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end
`else
    // Fixed increments straight from the parameter vector.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            inc[i] = INC_VEC[i*ACC_W +: ACC_W];
        end
    end
`endif

endmodule

// File: tb/tb_clken_nco_gen.sv
// tb/tb_clken_nco_gen.sv - directed self-checking bench for clken_nco_gen
module tb_clken_nco_gen;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       sync;
    logic [1:0] ce;
    logic       ready;
    logic [7:0] lost_cnt;
`ifdef CLKEN_DYN_INC_EN
    logic       inc_wr;
    logic [1:0] inc_sel;
    logic [7:0] inc_data;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    clken_nco_gen #(
        .NUM_CH      (2),
        .ACC_W       (8),
        .INC_VEC     ({8'd96, 8'd64}),
        .LOCK_CYCLES (16)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .sync       (sync),
        .ce         (ce),
        .ready      (ready),
        .lost_cnt   (lost_cnt)
`ifdef CLKEN_DYN_INC_EN
        ,
        .inc_wr     (inc_wr),
        .inc_sel    (inc_sel),
        .inc_data   (inc_data)
`endif
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Counts edges until ready is seen; n = -1 when the budget expires. early_ce flags ce before ready.
    task automatic wait_ready(input int max, output int n, output int early_ce);
        n = -1;
        early_ce = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (ready) begin
                n = k;
                break;
            end
            if (ce != 2'b00) early_ce = 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, early;
        int first0, first1, cnt0, cnt1, prev1, k1, gap_bad, p0_bad, exp_gap;
        int loss_bad;

        rst = 1'b1;
        pll_locked = 1'b0;
        sync = 1'b0;
`ifdef CLKEN_DYN_INC_EN
        inc_wr = 1'b0;
        inc_sel = 2'd0;
        inc_data = 8'd0;
`endif
        tick(); tick(); tick();
        check("reset_ready", ready, 0);
        check("reset_ce", ce, 0);
        check("reset_lost", lost_cnt, 0);

        rst = 1'b0;
        tick(); tick(); tick();
        check("unlocked_ready", ready, 0);

        // Lock sequencing: 2 sync edges + 1 WAIT_LOCK edge + 16 SETTLE edges.
        pll_locked = 1'b1;
        wait_ready(40, n, early);
        check("lock_latency", n, 19);
        check("ce_before_ready", early, 0);

        // Rate and phase over 96 cycles: ch0 inc 64, ch1 inc 96.
        first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0;
        prev1 = 0; k1 = 0; gap_bad = 0; p0_bad = 0;
        for (int t = 1; t <= 96; t++) begin
            tick();
            if (ce[0] !== ((t % 4) == 0)) p0_bad++;
            if (ce[0]) begin
                cnt0++;
                if (first0 < 0) first0 = t;
            end
            if (ce[1]) begin
                cnt1++;
                if (first1 < 0) first1 = t;
                exp_gap = ((k1 % 3) == 2) ? 2 : 3;
                if ((t - prev1) != exp_gap) gap_bad++;
                prev1 = t;
                k1++;
            end
        end
        check("ch0_first", first0, 4);
        check("ch0_count", cnt0, 24);
        check("ch0_period", p0_bad, 0);
        check("ch1_first", first1, 3);
        check("ch1_count", cnt1, 36);
        check("ch1_spacing", gap_bad, 0);

        // Sync on the ch0 wrap edge (cycle 100): wrap suppressed, both phases cleared.
        tick(); tick(); tick();
        check("ch1_pulse_c99", ce[1], 1);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_ce0", ce[0], 0);
        check("sync_ce1", ce[1], 0);
        first0 = -1; first1 = -1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (ce[0] && first0 < 0) first0 = t;
            if (ce[1] && first1 < 0) first1 = t;
        end
        check("post_sync_ch0_first", first0, 4);
        check("post_sync_ch1_first", first1, 3);
        check("pre_rst_ce0_high", ce[0], 1);

        // Asynchronous reset while ce[0] is high.
        rst = 1'b1;
        #1;
        check("async_rst_ce", ce, 0);
        check("async_rst_ready", ready, 0);
        pll_locked = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();

        // One-cycle lock glitch at SETTLE count 10 restarts the full wait.
        pll_locked = 1'b1;
        for (int t = 0; t < 13; t++) tick();
        check("glitch_not_ready", ready, 0);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_ready(40, n, early);
        check("glitch_relock_latency", n, 19);
        check("glitch_lost", lost_cnt, 0);

        // 300 lock losses in RUN; lost_cnt saturates.
        loss_bad = 0;
        for (int k = 1; k <= 300; k++) begin
            pll_locked = 1'b0;
            tick(); tick(); tick();
            if (ready !== 1'b0 || ce !== 2'b00) loss_bad++;
            if (k == 1)   check("lost_1", lost_cnt, 1);
            if (k == 254) check("lost_254", lost_cnt, 254);
            if (k == 255) check("lost_255", lost_cnt, 255);
            if (k < 300) begin
                pll_locked = 1'b1;
                wait_ready(40, n, early);
                if (n != 19) loss_bad++;
            end
        end
        check("loss_ready_ce", loss_bad, 0);
        check("lost_saturated", lost_cnt, 255);

`ifdef CLKEN_DYN_INC_EN
        // Write 128 to ch0 mid-period: old 4-cycle period completes, then period 2.
        pll_locked = 1'b1;
        wait_ready(40, n, early);
        check("dyn_ready", n, 19);
        n = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (ce[0]) begin
                n = t;
                break;
            end
        end
        check("dyn_first_ce0", n, 4);
        tick();
        inc_wr = 1'b1; inc_sel = 2'd0; inc_data = 8'd128;
        tick();
        inc_wr = 1'b0;
        for (int s = 3; s <= 8; s++) begin
            tick();
            check("dyn_apply_pattern", ce[0], (s >= 4) && ((s % 2) == 0));
        end
        inc_wr = 1'b1; inc_sel = 2'd3; inc_data = 8'd32;
        for (int s = 9; s <= 14; s++) begin
            tick();
            inc_wr = 1'b0;
            check("dyn_sel3_ignored", ce[0], (s % 2) == 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
